echo_indication_p2m: RTL and testbench
======================================

Name: echo_indication_p2m

Overview:
- Receive-side demarshaller for the Echo indication pipe.
- Accepts 128-bit messages produced by the indication method-to-pipe marshaller and re-issues them as heard / heard2 / heard3 method calls toward the host-side consumer.
- Buffers up to 2 messages, validates the header, and drops and counts malformed messages.
- Sits at the far end of the indication pipe, mirroring the request-side pipe-to-method block.

Parameters:
- DEPTH, 2, message buffer entries (power of 2, ≥2).
- CNTW, 16, width of the drop counter.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- pipe$enq__ENA  input  1  message valid/enqueue.
- pipe$enq$v  input  128  message.
- pipe$enq__RDY  output  1  buffer can accept a message.
- method$heard__ENA  output  1  heard call.
- method$heard$v  output  32  heard argument v.
- method$heard__RDY  input  1  consumer ready for heard.
- method$heard2__ENA  output  1  heard2 call.
- method$heard2$a  output  16  heard2 argument a.
- method$heard2$b  output  16  heard2 argument b.
- method$heard2__RDY  input  1  consumer ready for heard2.
- method$heard3__ENA  output  1  heard3 call.
- method$heard3$a  output  16  heard3 argument a.
- method$heard3$b  output  32  heard3 argument b.
- method$heard3$c  output  32  heard3 argument c.
- method$heard3$d  output  16  heard3 argument d.
- method$heard3__RDY  input  1  consumer ready for heard3.
- drop_count  output  CNTW  saturating count of dropped messages.

Behaviour:
- Clock and reset: single clock CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - Buffer empty; rd/wr pointers 0; drop_count 0.
  - All __ENA outputs 0; all argument outputs 0.
  - pipe$enq__RDY forced 0 while nRST low.
- Message format:
  - v[15:0] method id.
  - v[31:16] length in 32-bit words, header included.
  - Payload from bit 32, arguments packed in declaration order, LSB first.
- Method table:
  - heard: id 0, len 2, v = v[63:32].
  - heard2: id 1, len 2, a = v[47:32], b = v[63:48].
  - heard3: id 2, len 4, a = v[47:32], b = v[79:48], c = v[111:80], d = v[127:112].
- Enqueue:
  - pipe$enq__RDY = !full, from registered state only (no same-cycle pop pass-through).
  - A write occurs when ENA && RDY. ENA while !RDY is a protocol violation, ignored.
- Dispatch from the buffer head, combinational from registered head entry:
  - Valid head with known id and correct length: assert the matching __ENA only if that method's __RDY=1. Pop on the same edge.
  - Argument outputs are driven from the head whenever the head is valid. They are 0 when the buffer is empty.
  - Valid head with unknown id (≥3) or length mismatch: no __ENA. Pop immediately; drop_count += 1, saturating at all-ones.
  - Head blocked by __RDY=0 stalls in order; no reordering or bypass of later messages.
- At most one __ENA is high per cycle.
- Latency: a message accepted at edge N can produce __ENA in cycle N+1. Sustained throughput is 1 message/cycle when the consumer is always ready.
- Simultaneous push and pop: both occur and occupancy is unchanged, allowed whenever not full.
- Full buffer: RDY=0 even if a pop happens that cycle.
- Pointers wrap modulo DEPTH; full/empty are derived from a count register of width clog2(DEPTH)+1.
- Reset mid-operation: buffered messages are discarded, and no __ENA is emitted in the cycle nRST deasserts.

Decomposition:
- Shared package holds:
  - Method id constants HEARD_ID = 0, HEARD2_ID = 1, HEARD3_ID = 2.
  - Expected lengths, header field offsets, and a 128-bit message typedef.
- Sub-module: echo_msg_fifo, a generic DEPTH×128 register FIFO with enq/deq/full/empty and count.
- Decode and dispatch stay in the top block.

Test Plan:
- Reset with nRST=0 mid-stream holding 2 messages; release → drop_count=0, all __ENA=0 and the buffer empty; pipe$enq__RDY=1 one cycle after release.
- heard path: enq v={64'h0,32'hDEADBEEF,16'd2,16'd0}, heard__RDY=1 → next cycle heard__ENA=1, heard$v=32'hDEADBEEF, for one cycle only.
- heard3 path: enq id 2, len 4, a=16'h1234, b=32'hCAFEF00D, c=32'h01020304, d=16'hBEEF → heard3__ENA=1 with exactly those values.
- Back-pressure: heard2__RDY=0 and enq 3 heard2 messages → third enq sees RDY=0; then raise heard2__RDY → 3 ENA pulses in enq order on consecutive cycles.
- Malformed messages: enq id 7, then id 0 with len 3 → no __ENA, drop_count=2; a following valid heard is delivered normally.
- Saturation and throughput: force drop_count to 16'hFFFE via 3 bad messages plus preload → drop_count holds at 16'hFFFF. Streaming 16 valid heard messages with RDY=1 → 16 ENA pulses back-to-back.

Source files
------------

// File: rtl/echo_indication_p2m_pkg.sv
// Shared definitions for the Echo indication pipe-to-method demarshaller:
// method ids, expected message lengths, header field offsets and the message type.
package echo_indication_p2m_pkg;

  localparam int MSG_W = 128;

  typedef logic [MSG_W-1:0] msg_t;

  // Method ids carried in the low header half-word
  localparam logic [15:0] HEARD_ID  = 16'd0;
  localparam logic [15:0] HEARD2_ID = 16'd1;
  localparam logic [15:0] HEARD3_ID = 16'd2;

  // Message lengths in 32-bit words, header included
  localparam logic [15:0] HEARD_LEN  = 16'd2;
  localparam logic [15:0] HEARD2_LEN = 16'd2;
  localparam logic [15:0] HEARD3_LEN = 16'd4;

  // Header layout
  localparam int ID_LSB      = 0;
  localparam int LEN_LSB     = 16;
  localparam int PAYLOAD_LSB = 32;

  function automatic logic [15:0] msg_id(input msg_t m);
    return m[ID_LSB +: 16];
  endfunction

  function automatic logic [15:0] msg_len(input msg_t m);
    return m[LEN_LSB +: 16];
  endfunction

endpackage

// File: rtl/echo_indication_p2m_fifo.sv
// Generic DEPTH-entry register FIFO; occupancy tracked by a count register
// one bit wider than the pointers so full and empty are unambiguous.
module echo_msg_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 128
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enq,
  input  logic [W-1:0] i_data,
  input  logic         i_deq,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_enq;
  logic             w_do_deq;

  assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_do_enq = i_enq && !o_full;
  assign w_do_deq = i_deq && !o_empty;
  assign o_data   = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Message storage; contents are qualified by the count, so no reset needed
  always_ff @(posedge i_clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/echo_indication_p2m.sv
// Echo indication demarshaller: buffers 128-bit pipe messages, validates the
// header at the buffer head and re-issues them as heard/heard2/heard3 calls.
// Malformed heads are discarded and counted in a saturating drop counter.
module echo_indication_p2m
  import echo_indication_p2m_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pipe_enq__ENA,
  input  logic [127:0]    pipe_enq_v,
  output logic            pipe_enq__RDY,
  output logic            method_heard__ENA,
  output logic [31:0]     method_heard_v,
  input  logic            method_heard__RDY,
  output logic            method_heard2__ENA,
  output logic [15:0]     method_heard2_a,
  output logic [15:0]     method_heard2_b,
  input  logic            method_heard2__RDY,
  output logic            method_heard3__ENA,
  output logic [15:0]     method_heard3_a,
  output logic [31:0]     method_heard3_b,
  output logic [31:0]     method_heard3_c,
  output logic [15:0]     method_heard3_d,
  input  logic            method_heard3__RDY,
  output logic [CNTW-1:0] drop_count
);

  msg_t            w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_head_vld;
  logic            w_push;
  logic            w_pop;
  logic            w_is_heard;
  logic            w_is_heard2;
  logic            w_is_heard3;
  logic            w_bad;
  logic [15:0]     w_id;
  logic [15:0]     w_len;
  logic [CNTW-1:0] r_drop_count;

  // Refused while in reset and whenever the buffer is full; no pop pass-through
  assign pipe_enq__RDY = nRST && !w_full;
  assign w_push        = pipe_enq__ENA && pipe_enq__RDY;

  echo_msg_fifo #(
    .DEPTH (DEPTH),
    .W     (MSG_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_enq   (w_push),
    .i_data  (pipe_enq_v),
    .i_deq   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_vld = !w_empty;
  assign w_id       = msg_id(w_head);
  assign w_len      = msg_len(w_head);

  // Head classification: a method is recognised only with its exact length
  assign w_is_heard  = (w_id == HEARD_ID)  && (w_len == HEARD_LEN);
  assign w_is_heard2 = (w_id == HEARD2_ID) && (w_len == HEARD2_LEN);
  assign w_is_heard3 = (w_id == HEARD3_ID) && (w_len == HEARD3_LEN);
  assign w_bad       = w_head_vld && !(w_is_heard || w_is_heard2 || w_is_heard3);

  // At most one call fires: the classifications are mutually exclusive
  assign method_heard__ENA  = w_head_vld && w_is_heard  && method_heard__RDY;
  assign method_heard2__ENA = w_head_vld && w_is_heard2 && method_heard2__RDY;
  assign method_heard3__ENA = w_head_vld && w_is_heard3 && method_heard3__RDY;

  // Delivered or discarded heads leave the buffer on the same edge
  assign w_pop = method_heard__ENA || method_heard2__ENA || method_heard3__ENA || w_bad;

  // Arguments mirror the head whenever it is valid, zero when empty
  always_comb begin
    method_heard_v  = '0;
    method_heard2_a = '0;
    method_heard2_b = '0;
    method_heard3_a = '0;
    method_heard3_b = '0;
    method_heard3_c = '0;
    method_heard3_d = '0;
    if (w_head_vld) begin
      method_heard_v  = w_head[PAYLOAD_LSB +: 32];
      method_heard2_a = w_head[PAYLOAD_LSB +: 16];
      method_heard2_b = w_head[PAYLOAD_LSB+16 +: 16];
      method_heard3_a = w_head[PAYLOAD_LSB +: 16];
      method_heard3_b = w_head[PAYLOAD_LSB+16 +: 32];
      method_heard3_c = w_head[PAYLOAD_LSB+48 +: 32];
      method_heard3_d = w_head[PAYLOAD_LSB+80 +: 16];
    end
  end

  // Saturating count of discarded malformed messages
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_drop_count <= '0;
    end else if (w_bad && (r_drop_count != {CNTW{1'b1}})) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_echo_indication_p2m.sv
// Bench for echo_indication_p2m: directed scenarios followed by a random phase,
// all checked every cycle against a queue-based model of the message buffer.
module tb_echo_indication_p2m;

  localparam int DEPTH = 2;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         enq_ena;
  logic [127:0] enq_v;
  logic         enq_rdy, enq_rdy_s;
  logic         h_ena, h2_ena, h3_ena, h_rdy, h2_rdy, h3_rdy;
  logic         h_ena_s, h2_ena_s, h3_ena_s;
  logic [31:0]  h_v, h3_b, h3_c, h_v_s, h3_b_s, h3_c_s;
  logic [15:0]  h2_a, h2_b, h3_a, h3_d, h2_a_s, h2_b_s, h3_a_s, h3_d_s;
  logic [15:0]  drop_count;
  logic [1:0]   drop_small;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [127:0] q[$];
  int           m_drops;
  bit           last_acc;
  int           heard_pulses;

  always #5 CLK = ~CLK;

  echo_indication_p2m #(.DEPTH(DEPTH), .CNTW(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(enq_rdy),
    .method_heard__ENA(h_ena), .method_heard_v(h_v), .method_heard__RDY(h_rdy),
    .method_heard2__ENA(h2_ena), .method_heard2_a(h2_a), .method_heard2_b(h2_b),
    .method_heard2__RDY(h2_rdy),
    .method_heard3__ENA(h3_ena), .method_heard3_a(h3_a), .method_heard3_b(h3_b),
    .method_heard3_c(h3_c), .method_heard3_d(h3_d), .method_heard3__RDY(h3_rdy),
    .drop_count(drop_count)
  );

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly
  echo_indication_p2m #(.DEPTH(DEPTH), .CNTW(2)) dut_sat (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(enq_rdy_s),
    .method_heard__ENA(h_ena_s), .method_heard_v(h_v_s), .method_heard__RDY(h_rdy),
    .method_heard2__ENA(h2_ena_s), .method_heard2_a(h2_a_s), .method_heard2_b(h2_b_s),
    .method_heard2__RDY(h2_rdy),
    .method_heard3__ENA(h3_ena_s), .method_heard3_a(h3_a_s), .method_heard3_b(h3_b_s),
    .method_heard3_c(h3_c_s), .method_heard3_d(h3_d_s), .method_heard3__RDY(h3_rdy),
    .drop_count(drop_small)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] id, input logic [15:0] len,
                                      input logic [95:0] pl);
    return {pl, len, id};
  endfunction

  // 0 heard, 1 heard2, 2 heard3, 3 malformed
  function automatic int kind_of(input logic [127:0] m);
    int id, len;
    id  = int'(m[15:0]);
    len = int'(m[31:16]);
    if (id == 0 && len == 2) return 0;
    if (id == 1 && len == 2) return 1;
    if (id == 2 && len == 4) return 2;
    return 3;
  endfunction

  // One clock: check outputs at the falling edge against the model, then
  // advance the model across the rising edge.
  task automatic cyc();
    logic [127:0] hd;
    bit vld, exp_rdy, e1, e2, e3, pop, acc;
    int k;
    logic [175:0] exp_args, obs_args;
    @(negedge CLK);
    vld     = (q.size() > 0);
    hd      = vld ? q[0] : '0;
    k       = vld ? kind_of(hd) : -1;
    exp_rdy = nRST && (q.size() < DEPTH);
    e1 = (k == 0) && h_rdy;
    e2 = (k == 1) && h2_rdy;
    e3 = (k == 2) && h3_rdy;
    pop = e1 || e2 || e3 || (k == 3);
    acc = enq_ena && exp_rdy;
    exp_args = {hd[63:32], hd[47:32], hd[63:48],
                hd[47:32], hd[79:48], hd[111:80], hd[127:112]};
    obs_args = {h_v, h2_a, h2_b, h3_a, h3_b, h3_c, h3_d};
    chk("enq_rdy", 256'(enq_rdy), 256'(exp_rdy));
    chk("ena_vec", 256'({h_ena, h2_ena, h3_ena}), 256'({e1, e2, e3}));
    chk("args", 256'(obs_args), 256'(exp_args));
    chk("drop_count", 256'(drop_count), 256'((m_drops > 65535) ? 65535 : m_drops));
    chk("drop_count_sat", 256'(drop_small), 256'((m_drops > 3) ? 3 : m_drops));
    if (h_ena) heard_pulses++;
    @(posedge CLK);
    if (nRST) begin
      if (pop) begin
        if (k == 3) m_drops++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(enq_v);
    end
    last_acc = acc;
    #1;
  endtask

  // Present a message and hold it until accepted (bounded)
  task automatic send(input logic [127:0] m);
    enq_ena = 1'b1;
    enq_v   = m;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 256'(0), 256'(1));
    enq_ena = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; enq_ena = 1'b0; enq_v = '0;
    h_rdy = 1'b0; h2_rdy = 1'b0; h3_rdy = 1'b0;
    m_drops = 0; last_acc = 1'b0; heard_pulses = 0;
    repeat (2) @(posedge CLK);
    #1;
    cyc();
    nRST = 1'b1;
    cyc();

    // Fill the buffer with two stalled messages, then reset mid-stream
    send(mk(16'd0, 16'd2, 96'h1111));
    send(mk(16'd1, 16'd2, 96'h2222));
    cyc();
    nRST = 1'b0;
    q.delete();
    m_drops = 0;
    cyc();
    h_rdy = 1'b1; h2_rdy = 1'b1; h3_rdy = 1'b1;
    nRST = 1'b1;
    cyc();
    chk("post_reset_rdy", 256'(enq_rdy), 256'(1));

    // heard path
    send(mk(16'd0, 16'd2, {64'h0, 32'hDEADBEEF}));
    chk("heard_v", 256'(h_v), 256'(32'hDEADBEEF));
    chk("heard_ena", 256'(h_ena), 256'(1));
    cyc();
    chk("heard_once", 256'(h_ena), 256'(0));

    // heard3 path
    send(mk(16'd2, 16'd4, {16'hBEEF, 32'h01020304, 32'hCAFEF00D, 16'h1234}));
    chk("heard3_all", 256'({h3_ena, h3_a, h3_b, h3_c, h3_d}),
        256'({1'b1, 16'h1234, 32'hCAFEF00D, 32'h01020304, 16'hBEEF}));
    cyc();

    // Back-pressure on heard2
    h2_rdy = 1'b0;
    send(mk(16'd1, 16'd2, 96'h0000_A001));
    send(mk(16'd1, 16'd2, 96'h0000_A002));
    enq_ena = 1'b1; enq_v = mk(16'd1, 16'd2, 96'h0000_A003);
    cyc();
    chk("third_refused", 256'(last_acc), 256'(0));
    h2_rdy = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) cyc();
    enq_ena = 1'b0;
    repeat (3) cyc();

    // Malformed messages then a good one
    send(mk(16'd7, 16'd2, 96'h77));
    send(mk(16'd0, 16'd3, 96'h33));
    send(mk(16'd0, 16'd2, 96'h0000_5A5A));
    repeat (2) cyc();
    chk("two_drops", 256'(drop_count), 256'(2));

    // Saturate the narrow counter
    for (int i = 0; i < 3; i++) send(mk(16'd9, 16'd2, 96'h0));
    repeat (2) cyc();
    chk("sat_hold", 256'(drop_small), 256'(3));

    // Back-to-back streaming
    heard_pulses = 0;
    enq_ena = 1'b1;
    for (int i = 0; i < 16; i++) begin
      enq_v = mk(16'd0, 16'd2, 96'(32'h1000 + i));
      cyc();
      chk("stream_acc", 256'(last_acc), 256'(1));
    end
    enq_ena = 1'b0;
    repeat (3) cyc();
    chk("stream_pulses", 256'(heard_pulses), 256'(16));

    // Random traffic with random consumer readiness
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [15:0] id, len;
      r = int'($urandom_range(0, 9));
      id  = (r < 8) ? 16'(r % 3) : 16'($urandom_range(3, 20));
      len = (id == 16'd2) ? 16'd4 : 16'd2;
      if (r == 9) len = 16'($urandom_range(0, 6));
      enq_ena = ($urandom_range(0, 3) != 0);
      enq_v   = mk(id, len, {$urandom, $urandom, $urandom});
      h_rdy   = ($urandom_range(0, 2) != 0);
      h2_rdy  = ($urandom_range(0, 2) != 0);
      h3_rdy  = ($urandom_range(0, 2) != 0);
      cyc();
    end
    enq_ena = 1'b0; h_rdy = 1'b1; h2_rdy = 1'b1; h3_rdy = 1'b1;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
